dma_bus_scheduler: RTL and testbench

- Sequences the DMA engine and shares the memory bus between the CPU and the DMA.
- On a device-ready request it issues the one-cycle DMA command, then waits for the DMA bus request (BR) and for the CPU to drain its memory access.
- It then grants the bus (BG), counts DMA write cycles, takes the bus back when BR drops, and raises a completion interrupt to the CPU.
- Sits between CPU memory interface, DMA engine and memory; the only source of BG and cmd.

---
 rtl/dma_bus_scheduler_if.sv | 25 ++
 rtl/dma_bus_scheduler.sv | 133 +++++++++++++
 tb/tb_dma_bus_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_scheduler_if.sv
// Handshake bundle shared by the DMA bus scheduler, the CPU memory port and the DMA engine.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface dma_bus_scheduler_if;
  logic        dev_ready;
  logic        cmd;
  logic        BR;
  logic        BG;
  logic        dma_write;
  logic        cpu_mem_busy;
  logic        cpu_stall;
  logic        dma_done;
  logic        err;
  logic        err_clr;
  logic [15:0] xfer_count;

  modport slave (
    input  dev_ready, BR, dma_write, cpu_mem_busy, err_clr,
    output cmd, BG, cpu_stall, dma_done, err, xfer_count
  );

  modport master (
    output dev_ready, BR, dma_write, cpu_mem_busy, err_clr,
    input  cmd, BG, cpu_stall, dma_done, err, xfer_count
  );
endinterface

// File: rtl/dma_bus_scheduler.sv
// DMA sequencer and CPU/DMA memory-bus arbiter: cmd pulse, grant handshake, write counting, done irq.
// Optional macro CYCLE_STEAL_EN inserts a one-cycle CPU steal slot every STEAL_PERIOD counted writes.
module dma_bus_scheduler #(
  parameter int unsigned LENGTH       = 12,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned STEAL_PERIOD = 4
) (
  input  logic               CLK,
  input  logic               reset,
  dma_bus_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_BR,
    S_WAIT_CPU,
    S_GRANT,
    S_STEAL,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam logic [15:0] LEN_VAL   = 16'(LENGTH);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  state_t      r_state;
  logic [15:0] r_to_cnt;
  logic [15:0] r_xfer_count;
  logic        r_err;
  logic        r_cmd;
  logic        r_bg;
  logic        r_stall;
  logic        r_done;

  state_t      w_next;
  logic        w_write;
  logic [15:0] w_count_inc;
  logic        w_err_set;
  logic        w_start;

  // BG is high exactly while in GRANT, so a counted write is a strobe seen in that state.
  assign w_write     = (r_state == S_GRANT) && bus.dma_write;
  assign w_count_inc = (r_xfer_count == COUNT_MAX) ? r_xfer_count : r_xfer_count + 16'd1;
  assign w_start     = (r_state == S_IDLE) && (w_next == S_CMD);

  assign w_err_set = (w_write && (r_xfer_count == LEN_VAL))
                   || ((r_state == S_WAIT_BR) && !bus.BR && (r_to_cnt == TO_LAST))
                   || ((r_state == S_RELEASE) && (r_xfer_count != LEN_VAL));

`ifdef CYCLE_STEAL_EN
  logic [15:0] r_steal_cnt;
  logic        w_steal_hit;

  assign w_steal_hit = (r_steal_cnt == 16'(STEAL_PERIOD - 1));

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_steal_cnt <= '0;
    end else if (w_start) begin
      r_steal_cnt <= '0;
    end else if (w_write) begin
      r_steal_cnt <= w_steal_hit ? 16'd0 : r_steal_cnt + 16'd1;
    end
  end
`else
  // Without cycle stealing the steal period has no effect; this keeps it referenced.
  if (STEAL_PERIOD == 0) begin : g_steal_period_unused
  end
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.dev_ready) w_next = S_CMD;
      S_CMD:      w_next = S_WAIT_BR;
      S_WAIT_BR: begin
        if (bus.BR)                   w_next = S_WAIT_CPU;
        else if (r_to_cnt == TO_LAST) w_next = S_IDLE;
      end
      S_WAIT_CPU: if (!bus.cpu_mem_busy) w_next = S_GRANT;
      S_GRANT: begin
        if (!bus.BR) w_next = S_RELEASE;
`ifdef CYCLE_STEAL_EN
        else if (w_write && w_steal_hit && (w_count_inc != LEN_VAL)) w_next = S_STEAL;
`endif
      end
`ifdef CYCLE_STEAL_EN
      S_STEAL:    w_next = bus.BR ? S_GRANT : S_RELEASE;
`endif
      S_RELEASE:  w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_to_cnt     <= '0;
      r_xfer_count <= '0;
      r_err        <= 1'b0;
      r_cmd        <= 1'b0;
      r_bg         <= 1'b0;
      r_stall      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cmd    <= (w_next == S_CMD);
      r_bg     <= (w_next == S_GRANT);
      r_stall  <= (w_next inside {S_WAIT_CPU, S_GRANT, S_RELEASE});
      r_done   <= (w_next == S_DONE);
      r_to_cnt <= (r_state == S_WAIT_BR) ? r_to_cnt + 16'd1 : 16'd0;

      if (w_start)      r_xfer_count <= '0;
      else if (w_write) r_xfer_count <= w_count_inc;

      // A set condition in the same cycle as err_clr wins.
      r_err <= w_err_set | (r_err & ~bus.err_clr);
    end
  end

  assign bus.cmd        = r_cmd;
  assign bus.BG         = r_bg;
  assign bus.cpu_stall  = r_stall;
  assign bus.dma_done   = r_done;
  assign bus.err        = r_err;
  assign bus.xfer_count = r_xfer_count;

endmodule

// File: tb/tb_dma_bus_scheduler.sv
// Directed bench for dma_bus_scheduler: a vector table for the nominal transfer plus
// hand-written sequences for async reset, WAIT_BR timeout, overrun and short transfers.
module tb_dma_bus_scheduler;

  localparam int LENGTH       = 12;
  localparam int TIMEOUT      = 64;
  localparam int STEAL_PERIOD = 4;
`ifdef CYCLE_STEAL_EN
  localparam bit STEAL_ON = 1'b1;
`else
  localparam bit STEAL_ON = 1'b0;
`endif

  logic CLK = 1'b0;
  logic reset;

  dma_bus_scheduler_if bus ();

  dma_bus_scheduler #(
    .LENGTH      (LENGTH),
    .TIMEOUT     (TIMEOUT),
    .STEAL_PERIOD(STEAL_PERIOD)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        dev_ready;
    logic        br;
    logic        wr;
    logic        busy;
    logic        clr;
    logic        cmd;
    logic        bg;
    logic        stall;
    logic        done;
    logic        err;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dev, input logic br, input logic wr, input logic busy,
                       input logic clr);
    bus.dev_ready    = dev;
    bus.BR           = br;
    bus.dma_write    = wr;
    bus.cpu_mem_busy = busy;
    bus.err_clr      = clr;
  endtask

  // One clock edge, then sample 1 time unit later; cmd/BG/dma_done must never overlap.
  task automatic step();
    @(posedge CLK);
    #1;
    check("cmd_bg_done_exclusive",
          32'($countones({bus.cmd, bus.BG, bus.dma_done}) <= 1), 32'd1);
  endtask

  function automatic void add(input logic dev, input logic br, input logic wr, input logic busy,
                              input logic clr, input logic cmd, input logic bg,
                              input logic stall, input logic done, input logic err,
                              input logic [15:0] cnt);
    vec_t v;
    v.dev_ready = dev; v.br = br; v.wr = wr; v.busy = busy; v.clr = clr;
    v.cmd = cmd; v.bg = bg; v.stall = stall; v.done = done; v.err = err; v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  // dev_ready pulse, then BR and cpu_mem_busy=0 until BG rises (three edges expected).
  task automatic start_xfer(input string tag);
    int n = 0;
    drive(1, 0, 0, 0, 0);
    step();
    check({tag, "_cmd"}, 32'(bus.cmd), 32'd1);
    check({tag, "_cnt_cleared"}, 32'(bus.xfer_count), 32'd0);
    drive(0, 1, 0, 0, 0);
    while (!bus.BG && n < 10) begin
      step();
      n++;
    end
    check({tag, "_edges_to_bg"}, 32'(n), 32'd3);
  endtask

  task automatic do_writes(input string tag, input int n);
    int guard = 0;
    bus.dma_write = 1'b1;
    while (int'(bus.xfer_count) < n && guard < 4 * n + 8) begin
      step();
      guard++;
    end
    bus.dma_write = 1'b0;
    check({tag, "_writes"}, 32'(bus.xfer_count), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  saw_bg;
    bit  saw_done;
    bit  steal_after;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1;
    check("reset_outputs",
          32'({bus.cmd, bus.BG, bus.cpu_stall, bus.dma_done, bus.err}), 32'd0);
    check("reset_count", 32'(bus.xfer_count), 32'd0);
    reset = 1'b0;

    // Async reset in the middle of GRANT with five writes counted.
    start_xfer("rst_seq");
    do_writes("rst_seq", 5);
    check("rst_seq_bg_before", 32'({bus.BG, bus.cpu_stall}), 32'b11);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_bg_stall", 32'({bus.BG, bus.cpu_stall}), 32'b00);
    check("rst_async_count", 32'(bus.xfer_count), 32'd0);
    #3;
    reset = 1'b0;
    drive(0, 1, 0, 0, 0);
    step();
    check("rst_idle_ignores_br", 32'({bus.cmd, bus.BG, bus.cpu_stall}), 32'b000);
    drive(0, 0, 0, 0, 0);

    // Nominal transfer: cpu_mem_busy holds off BG for 3 cycles, then LENGTH writes.
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 16'd0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 16'd0);
    add(0, 1, 0, 0, 0,  0, 0, 1, 0, 0, 16'd0);
    add(0, 1, 0, 1, 0,  0, 0, 1, 0, 0, 16'd0);
    add(0, 1, 1, 1, 0,  0, 0, 1, 0, 0, 16'd0);
    add(0, 1, 0, 1, 0,  0, 0, 1, 0, 0, 16'd0);
    add(0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 16'd0);
    for (int w = 1; w <= LENGTH; w++) begin
      steal_after = STEAL_ON && (w % STEAL_PERIOD == 0) && (w != LENGTH);
      add(0, 1, 1, 0, 0,  0, !steal_after, !steal_after, 0, 0, 16'(w));
      if (steal_after) add(0, 1, 1, 0, 0,  0, 1, 1, 0, 0, 16'(w));
    end
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 16'(LENGTH));
    add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 16'(LENGTH));
    add(1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 16'(LENGTH));
    add(0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 16'(LENGTH));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dev_ready, vecs[i].br, vecs[i].wr, vecs[i].busy, vecs[i].clr);
      step();
      check($sformatf("vec%0d_ctrl", i),
            32'({bus.cmd, bus.BG, bus.cpu_stall, bus.dma_done, bus.err}),
            32'({vecs[i].cmd, vecs[i].bg, vecs[i].stall, vecs[i].done, vecs[i].err}));
      check($sformatf("vec%0d_count", i), 32'(bus.xfer_count), 32'(vecs[i].cnt));
    end
    drive(0, 0, 0, 0, 0);

    // BR never rises: 64 edges spent in WAIT_BR, then back to IDLE with err set.
    drive(1, 0, 0, 0, 0);
    step();
    check("to_cmd", 32'(bus.cmd), 32'd1);
    check("to_cnt_cleared", 32'(bus.xfer_count), 32'd0);
    drive(0, 0, 0, 0, 0);
    step();
    n = 0;
    saw_bg = 0;
    saw_done = 0;
    while (!bus.err && n < 200) begin
      step();
      n++;
      saw_bg   |= bus.BG;
      saw_done |= bus.dma_done;
    end
    check("to_cycles", 32'(n), 32'(TIMEOUT));
    check("to_no_bg_done", 32'({saw_bg, saw_done}), 32'd0);
    step();
    check("to_err_sticky", 32'(bus.err), 32'd1);
    check("to_idle", 32'({bus.cmd, bus.cpu_stall}), 32'd0);
    drive(0, 0, 0, 0, 1);
    step();
    check("to_err_clr", 32'(bus.err), 32'd0);
    drive(0, 0, 0, 0, 0);

    // Overrun: the write after LENGTH sets err even with err_clr asserted (set wins).
    start_xfer("ovr");
    do_writes("ovr", LENGTH);
    check("ovr_no_err_at_length", 32'(bus.err), 32'd0);
    drive(0, 1, 1, 0, 1);
    step();
    check("ovr_count", 32'(bus.xfer_count), 32'(LENGTH + 1));
    check("ovr_err_set_wins", 32'({bus.err, bus.BG}), 32'b11);
    drive(0, 0, 0, 0, 0);
    step();
    step();
    check("ovr_done", 32'({bus.dma_done, bus.err}), 32'b11);
    drive(0, 0, 0, 0, 1);
    step();
    check("ovr_err_cleared", 32'({bus.dma_done, bus.err}), 32'b00);
    drive(0, 0, 0, 0, 0);

    // Short transfer: BR drops after 10 writes.
    start_xfer("short");
    do_writes("short", 10);
    drive(0, 0, 0, 0, 0);
    step();
    check("short_release", 32'({bus.BG, bus.cpu_stall, bus.err}), 32'b010);
    step();
    check("short_done", 32'({bus.dma_done, bus.cpu_stall, bus.err}), 32'b101);
    check("short_count", 32'(bus.xfer_count), 32'd10);
    step();
    check("short_done_one_cycle", 32'(bus.dma_done), 32'd0);
    check("short_count_held", 32'(bus.xfer_count), 32'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
